// File: rtl/ip_gpio_ex_pkg.sv
// Shared constants and helpers for the Z80 GPIO expander: register offsets
// within a port slot, ICTRL bit positions and the edge-event function.
package ip_gpio_ex_pkg;

  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_DIR   = 2'd1,
    REG_IMASK = 2'd2,
    REG_ISTAT = 2'd3
  } reg_sel_e;

  localparam int ICTRL_RISING = 0;
  localparam int ICTRL_BOTH   = 1;

  // Per-bit events from the current and previous synchronised pin values.
  function automatic logic [7:0] edge_events(input logic [7:0] cur,
                                             input logic [7:0] prev,
                                             input logic [1:0] ictrl);
    logic [7:0] rise;
    logic [7:0] fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    if (ictrl[ICTRL_BOTH])        return rise | fall;
    else if (ictrl[ICTRL_RISING]) return rise;
    else                          return fall;
  endfunction

endpackage

// File: rtl/ip_gpio_ex_port.sv
// One 8-bit GPIO port: output latch, direction, interrupt mask, pin
// synchroniser, edge detector and sticky interrupt status.
module ip_gpio_ex_port
  import ip_gpio_ex_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] gpi,
  input  logic       data_we,
  input  logic       dir_we,
  input  logic       imask_we,
  input  logic       istat_we,
  input  logic [7:0] wdata,
  input  logic [1:0] ictrl,
  output logic [7:0] gpo,
  output logic [7:0] dir,
  output logic [7:0] imask,
  output logic [7:0] istat,
  output logic [7:0] pin
);

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0] dly_q, dly_d;
  logic [7:0] gpo_q, gpo_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] imask_q, imask_d;
  logic [7:0] istat_q, istat_d;
  logic [7:0] events;

  // NOTE: every variable gets its value on every path through always_comb,
  // otherwise synthesis infers a latch to hold the missing cases.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], gpi};
    dly_d   = sync_q[SYNC_STAGES-1];
    // Masking with the pre-write DIR keeps a 1->0 direction change silent.
    events  = edge_events(sync_q[SYNC_STAGES-1], dly_q, ictrl) & ~dir_q;
    gpo_d   = data_we  ? wdata : gpo_q;
    dir_d   = dir_we   ? wdata : dir_q;
    imask_d = imask_we ? wdata : imask_q;
    istat_d = (istat_q & ~(istat_we ? wdata : 8'h00)) | events;
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      dly_q   <= '0;
      gpo_q   <= '0;
      dir_q   <= '0;
      imask_q <= '0;
      istat_q <= '0;
    end else begin
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      gpo_q   <= gpo_d;
      dir_q   <= dir_d;
      imask_q <= imask_d;
      istat_q <= istat_d;
    end
  end

  assign gpo   = gpo_q;
  assign dir   = dir_q;
  assign imask = imask_q;
  assign istat = istat_q;
  assign pin   = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ip_gpio_ex.sv
// Z80 I/O-mapped GPIO expander: PORTS x 8-bit ports plus a shared ICTRL
// register, single-shot bus accesses and a registered interrupt request.
module ip_gpio_ex
  import ip_gpio_ex_pkg::*;
#(
  parameter logic [7:0] io_address  = 8'h10,
  parameter int         PORTS       = 2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               iorq_n,
  input  logic [7:0]         address,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [7:0]         wdata,
  output logic [7:0]         q,
  output logic               q_en,
  input  logic [8*PORTS-1:0] gpi,
  output logic [8*PORTS-1:0] gpo,
  output logic [8*PORTS-1:0] gpo_oe,
  output logic               int_n
);

  localparam logic [7:0] ICTRL_OFF = 8'(4 * PORTS);

  logic [7:0] offset;
  logic       hit, wr_act, rd_act, wr_pulse, rd_pulse, irq_any;
  reg_sel_e   reg_sel;
  logic [7:0] rd_mux;
  logic       wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
  logic [1:0] ictrl_q, ictrl_d;
  logic [7:0] q_q, q_d;
  logic       q_en_q, q_en_d;
  logic       int_n_q, int_n_d;

  logic [7:0] gpo_p   [PORTS];
  logic [7:0] dir_p   [PORTS];
  logic [7:0] imask_p [PORTS];
  logic [7:0] istat_p [PORTS];
  logic [7:0] pin_p   [PORTS];

  always_comb begin
    offset    = address - io_address;
    // The window never wraps: addresses below the base are simply not ours.
    hit       = !iorq_n && (address >= io_address) && (offset <= ICTRL_OFF);
    wr_act    = hit && !wr_n;
    rd_act    = hit && !rd_n;
    wr_pulse  = wr_act && !wr_prev_q;
    rd_pulse  = rd_act && !rd_prev_q;
    wr_prev_d = wr_act;
    rd_prev_d = rd_act;
    reg_sel   = reg_sel_e'(offset[1:0]);
    ictrl_d   = (wr_pulse && offset == ICTRL_OFF) ? wdata[1:0] : ictrl_q;

    rd_mux  = {6'b0, ictrl_q};
    irq_any = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      irq_any = irq_any | (|(istat_p[p] & imask_p[p]));
      if (offset[7:2] == 6'(p)) begin
        case (reg_sel)
          REG_DATA:  rd_mux = (gpo_p[p] & dir_p[p]) | (pin_p[p] & ~dir_p[p]);
          REG_DIR:   rd_mux = dir_p[p];
          REG_IMASK: rd_mux = imask_p[p];
          REG_ISTAT: rd_mux = istat_p[p];
        endcase
      end
    end

    q_d     = rd_pulse ? rd_mux : q_q;
    q_en_d  = rd_pulse;
    int_n_d = !irq_any;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Strobe history resets to "active" so a strobe still held when reset
      // releases must first go away before it counts as a new access.
      wr_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
      ictrl_q   <= '0;
      q_q       <= 8'hFF;
      q_en_q    <= 1'b0;
      int_n_q   <= 1'b1;
    end else begin
      wr_prev_q <= wr_prev_d;
      rd_prev_q <= rd_prev_d;
      ictrl_q   <= ictrl_d;
      q_q       <= q_d;
      q_en_q    <= q_en_d;
      int_n_q   <= int_n_d;
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic sel;
    assign sel = wr_pulse && (offset[7:2] == 6'(p));

    ip_gpio_ex_port #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_port (
      .clk      (clk),
      .rst_n    (reset_n),
      .gpi      (gpi[8*p +: 8]),
      .data_we  (sel && reg_sel == REG_DATA),
      .dir_we   (sel && reg_sel == REG_DIR),
      .imask_we (sel && reg_sel == REG_IMASK),
      .istat_we (sel && reg_sel == REG_ISTAT),
      .wdata    (wdata),
      .ictrl    (ictrl_q),
      .gpo      (gpo_p[p]),
      .dir      (dir_p[p]),
      .imask    (imask_p[p]),
      .istat    (istat_p[p]),
      .pin      (pin_p[p])
    );

    assign gpo[8*p +: 8]    = gpo_p[p];
    assign gpo_oe[8*p +: 8] = dir_p[p];
  end

  assign q     = q_q;
  assign q_en  = q_en_q;
  assign int_n = int_n_q;

endmodule
